// File: rtl/cpu_pkg.sv
// cpu_pkg: codes and defaults shared by the register file, the instruction
// decoder and the ALU, so that every block agrees on the write_op encoding.
package cpu_pkg;

  localparam int BUS_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_INC   = 2'd1,
    OP_DEC   = 2'd2,
    OP_CLEAR = 2'd3
  } write_op_t;

endpackage

// File: rtl/register_cell.sv
// register_cell: one BUS_WIDTH storage register with load enable and
// synchronous active-high reset.
//   clock  : rising-edge clock
//   reset  : synchronous, active-high, clears the stored value
//   load   : capture d on this edge
//   d      : value to capture
//   q      : stored value
module register_cell #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BUS_WIDTH-1:0] d,
  output logic [BUS_WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file: REG_COUNT registers of BUS_WIDTH bits with one write port
// (LOAD / INC / DEC / CLEAR) and two combinational read ports, optional
// write-to-read bypass and optional hardwired zero register.
//   clock        : rising-edge clock
//   reset        : synchronous, active-high; clears all registers and wrap
//   write_enable : apply write_op to write_addr on this edge
//   write_op     : 0 LOAD, 1 INC, 2 DEC, 3 CLEAR
//   write_addr   : target register
//   write_data   : LOAD operand
//   read_addr_a/b: read port addresses
//   read_data_a/b: read port data (combinational)
//   wrap         : high for one cycle after an INC/DEC that wrapped
module register_file
  import cpu_pkg::*;
#(
  parameter int BUS_WIDTH  = BUS_WIDTH_DEFAULT,
  parameter int REG_COUNT  = 8,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [1:0]            write_op,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [BUS_WIDTH-1:0]  write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  output logic [BUS_WIDTH-1:0]  read_data_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [BUS_WIDTH-1:0]  read_data_b,
  output logic                  wrap
);

  logic [BUS_WIDTH-1:0] regs [REG_COUNT];

  logic                 write_valid;
  logic                 write_accept;
  logic [BUS_WIDTH-1:0] current_value;
  logic [BUS_WIDTH-1:0] next_value;
  logic                 wrap_next;
  logic [BUS_WIDTH-1:0] stored_a;
  logic [BUS_WIDTH-1:0] stored_b;

  // Addresses past REG_COUNT (non-power-of-2 banks) and, when hardwired,
  // register 0 swallow the write entirely, including its wrap flag.
  assign write_valid  = (int'(write_addr) < REG_COUNT) &&
                        !((ZERO_REG != 0) && (write_addr == '0));
  assign write_accept = write_enable && write_valid;

  assign current_value = write_valid ? regs[write_addr] : '0;

  // Single next-value computation feeding both the target cell and bypass.
  always_comb begin
    next_value = current_value;
    wrap_next  = 1'b0;
    case (write_op)
      OP_LOAD:  next_value = write_data;
      OP_INC: begin
        next_value = current_value + 1'b1;
        wrap_next  = write_accept && (current_value == '1);
      end
      OP_DEC: begin
        next_value = current_value - 1'b1;
        wrap_next  = write_accept && (current_value == '0);
      end
      OP_CLEAR: next_value = '0;
      default:  next_value = current_value;
    endcase
  end

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_cell
      register_cell #(
        .BUS_WIDTH (BUS_WIDTH)
      ) u_cell (
        .clock (clock),
        .reset (reset),
        .load  (write_accept && (write_addr == ADDR_WIDTH'(i))),
        .d     (next_value),
        .q     (regs[i])
      );
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

  assign stored_a = (int'(read_addr_a) < REG_COUNT) ? regs[read_addr_a] : '0;
  assign stored_b = (int'(read_addr_b) < REG_COUNT) ? regs[read_addr_b] : '0;

  // Each port bypasses on its own; a discarded write never bypasses.
  assign read_data_a = ((BYPASS != 0) && write_accept && (read_addr_a == write_addr))
                       ? next_value : stored_a;
  assign read_data_b = ((BYPASS != 0) && write_accept && (read_addr_b == write_addr))
                       ? next_value : stored_b;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file. Two instances share all inputs:
// dut uses the defaults (ZERO_REG=1, BYPASS=1), alt uses ZERO_REG=0, BYPASS=0.
module tb_register_file;

  logic       clock = 1'b0;
  logic       reset;
  logic       write_enable;
  logic [1:0] write_op;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic [2:0] read_addr_a;
  logic [2:0] read_addr_b;
  logic [7:0] rda, rdb, alt_rda, alt_rdb;
  logic       wrap, alt_wrap;

  int checks = 0;
  int errors = 0;
  int model;

  always #5 clock = ~clock;

  register_file dut (
    .clock(clock), .reset(reset), .write_enable(write_enable), .write_op(write_op),
    .write_addr(write_addr), .write_data(write_data),
    .read_addr_a(read_addr_a), .read_data_a(rda),
    .read_addr_b(read_addr_b), .read_data_b(rdb), .wrap(wrap)
  );

  register_file #(.ZERO_REG(0), .BYPASS(0)) alt (
    .clock(clock), .reset(reset), .write_enable(write_enable), .write_op(write_op),
    .write_addr(write_addr), .write_data(write_data),
    .read_addr_a(read_addr_a), .read_data_a(alt_rda),
    .read_addr_b(read_addr_b), .read_data_b(alt_rdb), .wrap(alt_wrap)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one write on the next edge, then idle the write port.
  task automatic do_write(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data);
    write_enable = 1'b1;
    write_op     = op;
    write_addr   = addr;
    write_data   = data;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
    #1;
  endtask

  task automatic idle_cycle();
    @(posedge clock);
    #2;
  endtask

  initial begin
    // Reset overrides a simultaneous LOAD 0x55 -> r3
    reset = 1'b1; write_enable = 1'b1; write_op = 2'd0; write_addr = 3'd3;
    write_data = 8'h55; read_addr_a = '0; read_addr_b = '0;
    @(posedge clock);
    #1;
    reset = 1'b0; write_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_addr_a = 3'(i);
      #1;
      check($sformatf("reset_dut_r%0d", i), rda, 8'h00);
      check($sformatf("reset_alt_r%0d", i), alt_rda, 8'h00);
    end
    check("reset_wrap", {7'd0, wrap}, 8'h00);

    // Load and dual read
    do_write(2'd0, 3'd1, 8'h12);
    do_write(2'd0, 3'd2, 8'h34);
    read_addr_a = 3'd1; read_addr_b = 3'd2; #1;
    check("dual_read_a", rda, 8'h12);
    check("dual_read_b", rdb, 8'h34);

    // Increment / decrement wrap on r4
    read_addr_a = 3'd4;
    do_write(2'd0, 3'd4, 8'hFF);
    check("load_ff_wrap", {7'd0, wrap}, 8'h00);
    do_write(2'd1, 3'd4, 8'h00);
    check("inc_wrap_val", rda, 8'h00);
    check("inc_wrap_flag", {7'd0, wrap}, 8'h01);
    idle_cycle();
    check("wrap_one_cycle", {7'd0, wrap}, 8'h00);
    do_write(2'd2, 3'd4, 8'h00);
    check("dec_wrap_val", rda, 8'hFF);
    check("dec_wrap_flag", {7'd0, wrap}, 8'h01);
    do_write(2'd1, 3'd4, 8'h00);
    check("inc2_wrap_val", rda, 8'h00);
    check("inc2_wrap_flag", {7'd0, wrap}, 8'h01);
    do_write(2'd0, 3'd4, 8'h10);
    check("load_clears_wrap", {7'd0, wrap}, 8'h00);
    do_write(2'd1, 3'd4, 8'h00);
    check("inc_nowrap_val", rda, 8'h11);
    check("inc_nowrap_flag", {7'd0, wrap}, 8'h00);
    do_write(2'd3, 3'd4, 8'h00);
    check("clear_val", rda, 8'h00);
    read_addr_a = 3'd1; #1;
    check("r1_held", rda, 8'h12);

    // Bypass: LOAD 0xA5 -> r5 seen before the edge only when BYPASS=1
    write_enable = 1'b1; write_op = 2'd0; write_addr = 3'd5; write_data = 8'hA5;
    read_addr_a = 3'd5; read_addr_b = 3'd5; #1;
    check("bypass_load_dut", rda, 8'hA5);
    check("bypass_load_alt", alt_rda, 8'h00);
    @(posedge clock); #1;
    write_enable = 1'b0; #1;
    check("after_load_alt", alt_rda, 8'hA5);
    write_enable = 1'b1; write_op = 2'd1; #1;
    check("bypass_inc_dut_b", rdb, 8'hA6);
    check("bypass_inc_alt_b", alt_rdb, 8'hA5);
    @(posedge clock); #1;
    write_enable = 1'b0; #1;
    check("after_inc_dut", rda, 8'hA6);

    // Zero register
    read_addr_a = 3'd0;
    do_write(2'd0, 3'd0, 8'h7F);
    write_enable = 1'b1; write_op = 2'd1; write_addr = 3'd0; #1;
    check("zero_bypass_dut", rda, 8'h00);
    check("zero_nobypass_alt", alt_rda, 8'h7F);
    @(posedge clock); #1;
    write_enable = 1'b0; #1;
    check("zero_dut_val", rda, 8'h00);
    check("zero_dut_wrap", {7'd0, wrap}, 8'h00);
    check("r0_alt_val", alt_rda, 8'h80);
    do_write(2'd3, 3'd0, 8'h00);
    do_write(2'd2, 3'd0, 8'h00);
    check("zero_dec_dut_wrap", {7'd0, wrap}, 8'h00);
    check("r0_dec_alt_wrap", {7'd0, alt_wrap}, 8'h01);
    check("r0_dec_alt_val", alt_rda, 8'hFF);

    // Back-to-back INC on r6 with reset on cycle 5
    read_addr_a = 3'd6;
    model = 0;
    for (int i = 0; i < 10; i++) begin
      reset = (i == 5);
      write_enable = 1'b1; write_op = 2'd1; write_addr = 3'd6;
      @(posedge clock); #1;
      model = (i == 5) ? 0 : model + 1;
      check($sformatf("b2b_alt_%0d", i), alt_rda, 8'(model));
    end
    reset = 1'b0; write_enable = 1'b0; #1;
    check("b2b_dut_final", rda, 8'h04);
    read_addr_a = 3'd1; #1;
    check("reset_cleared_r1", rda, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-register storage block: REG_COUNT registers of BUS_WIDTH bits, one write port with per-write operation (load, increment, decrement, clear), and two combinational read ports. It generalises the single load-enabled D flip-flop register to the register bank feeding the CPU datapath's ALU operands. It provides optional write-to-read bypass and an optional hardwired zero register.

## Interface
Parameters:
- BUS_WIDTH, 8, width of every register and data port
- REG_COUNT, 8, number of registers (≥2)
- ADDR_WIDTH, $clog2(REG_COUNT), address width
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a read of the register being written returns the value being written this cycle

Ports:
- clock  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high; clears all state
- write_enable  input  1  perform write_op on write_addr this cycle
- write_op  input  2  0 LOAD, 1 INC, 2 DEC, 3 CLEAR
- write_addr  input  ADDR_WIDTH  target register
- write_data  input  BUS_WIDTH  operand for LOAD
- read_addr_a  input  ADDR_WIDTH  port A address
- read_data_a  output  BUS_WIDTH  port A data (combinational)
- read_addr_b  input  ADDR_WIDTH  port B address
- read_data_b  output  BUS_WIDTH  port B data (combinational)
- wrap  output  1  registered; high for one cycle after an INC/DEC that wrapped

## Operation
- Next value of the target register: LOAD → write_data; INC → reg+1 mod 2^BUS_WIDTH; DEC → reg−1 mod 2^BUS_WIDTH; CLEAR → 0.
- Only the addressed register changes. All others hold.
- write_enable=0: no register changes; wrap goes to 0 next edge.
- wrap next value = write_enable & ((INC & reg==all-ones) | (DEC & reg==0)). LOAD/CLEAR give wrap=0.
- ZERO_REG=1: writes to address 0 are discarded, including INC/DEC, so wrap stays 0; reads of address 0 return 0.
- write_addr ≥ REG_COUNT (non-power-of-2 counts): write discarded, wrap=0. Reads of such addresses return 0.
- Reads: read_data_x = stored value of read_addr_x.
- BYPASS=1 and write_enable & read_addr_x==write_addr & write not discarded: read_data_x = computed next value instead. Both ports bypass independently.
- BYPASS=0: reads always return the stored value.

## Timing
- Reset: on a clock edge with reset=1, all registers become 0 and wrap becomes 0. Reset overrides any simultaneous write.
- Reset asserted mid-sequence takes effect at that edge. The first write is accepted on the first edge with reset=0.
- Write latency: 1 edge; the stored value is visible on a non-bypassed read after the edge.
- Bypassed read latency: 0 cycles (same cycle as write_enable).
- wrap is valid for the cycle after the wrapping edge.
- Back-to-back INC on the same register every cycle advances it by 1 per edge, with no stall.
- Read ports are purely combinational from the stored array, the address inputs, and the write inputs. There are no read enables.

## Structure
- Shared package (cpu_pkg): write_op encodings (OP_LOAD, OP_INC, OP_DEC, OP_CLEAR) and the default BUS_WIDTH constant, so the decoder and ALU use the same codes.
- Sub-module register_cell: one BUS_WIDTH register with load-enable and synchronous reset. register_file instantiates REG_COUNT of these (register 0 omitted when ZERO_REG=1).
- The next-value / wrap computation is shared once in register_file and drives both the selected cell and the bypass mux.

## Test plan
- Reset then read: assert reset with write_enable=1, LOAD 0x55 to r3 → after the edge every address reads 0x00 and wrap=0.
- Load and dual read: LOAD 0x12→r1, LOAD 0x34→r2; read_addr_a=1, read_addr_b=2 → read_data_a=0x12 and read_data_b=0x34; r1 is unchanged when r2 is written.
- Increment/decrement wrap: LOAD 0xFF→r4, INC r4 → r4=0x00 and wrap=1 for exactly one cycle; then DEC r4 → 0xFF and wrap=1; then INC r4 → 0x00 and wrap=1; LOAD → wrap=0.
- Bypass: write LOAD 0xA5→r5 with read_addr_a=5 in the same cycle → read_data_a=0xA5 before the edge. With BYPASS=0 it shows the old value until after the edge.
- Zero register: LOAD 0x7F→r0 and INC r0 → r0 reads 0 and wrap=0; with ZERO_REG=0 r0 reads 0x80 after both writes.
- Back-to-back: INC r6 for 10 consecutive cycles from 0 → r6=10; assert reset on cycle 5 → r6=0, then increments to 4 over the remaining cycles.
